multicycle_main_control: RTL and testbench

// - Main control FSM for the multi-cycle MIPS datapath; the producer side of the
//   3-bit ALUOp code that the ALU control decoder turns into an ALU operation.
// - Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK from opcode_i; drives every

---
 rtl/multicycle_main_control_pkg.sv | 76 +++++++
 rtl/multicycle_main_control_if.sv | 49 ++++
 rtl/multicycle_main_control_mem_wait_counter.sv | 44 ++++
 rtl/multicycle_main_control.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_main_control_pkg.sv
// ============================================================================
//  Package    : mips_ctrl_pkg
//  Description: Opcodes, ALUOp codes, mux select codes and FSM states shared by
//               the multi-cycle MIPS main controller and its interface.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

   localparam int OPCODE_W = 6;
   localparam int ALUOP_W  = 3;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

   localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b001;
   localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 3'b010;
   localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b011;
   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b100;
   localparam logic [ALUOP_W-1:0] ALUOP_MEM   = 3'b101;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b110;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b111;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_R_EXEC    = 4'd2,
      S_R_WB      = 4'd3,
      S_I_EXEC    = 4'd4,
      S_I_WB      = 4'd5,
      S_MEM_ADDR  = 4'd6,
      S_MEM_READ  = 4'd7,
      S_MEM_WB    = 4'd8,
      S_MEM_WRITE = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11
   } state_t;

   // States that wait on the shared memory and therefore run the wait counter.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

   function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OPCODE_W-1:0] op);
      logic [ALUOP_W-1:0] r;
      r = ALUOP_ADD;
      case (op)
         OP_ANDI: r = ALUOP_AND;
         OP_ORI:  r = ALUOP_OR;
         OP_LUI:  r = ALUOP_LUI;
         default: r = ALUOP_ADD;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_main_control_if.sv
// ============================================================================
//  Interface  : multicycle_main_control_if
//  Description: Controller <-> datapath/memory bundle; master = controller.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_main_control_if;
   import mips_ctrl_pkg::*;

   logic [OPCODE_W-1:0] opcode_i;
   logic                mem_ready_i;
   logic                zero_i;
   logic                pc_write_o;
   logic                pc_write_cond_o;
   logic                branch_ne_o;
   logic                i_or_d_o;
   logic                mem_read_o;
   logic                mem_write_o;
   logic                ir_write_o;
   logic                reg_dst_o;
   logic                mem_to_reg_o;
   logic                reg_write_o;
   logic                alu_src_a_o;
   logic [1:0]          alu_src_b_o;
   logic [1:0]          pc_source_o;
   logic [ALUOP_W-1:0]  alu_op_o;
   logic                illegal_op_o;
   logic                mem_timeout_o;

   modport master (
      input  opcode_i, mem_ready_i, zero_i,
      output pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o,
             mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
             alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o, illegal_op_o,
             mem_timeout_o
   );

   modport slave (
      output opcode_i, mem_ready_i, zero_i,
      input  pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o,
             mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
             alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o, illegal_op_o,
             mem_timeout_o
   );

endinterface

`default_nettype wire

// File: rtl/multicycle_main_control_mem_wait_counter.sv
// ============================================================================
//  Module     : mem_wait_counter
//  Description: Saturating count of memory wait cycles with a saturate flag.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_counter #(
   parameter int WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output logic sat_o
);

   localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign sat_o = (cnt_q == CNT_W'(WAIT_MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && !sat_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_main_control.sv
// ============================================================================
//  Module     : multicycle_main_control
//  Description: Main control FSM of the multi-cycle MIPS datapath.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_main_control
   import mips_ctrl_pkg::*;
#(
   parameter state_t RESET_STATE  = S_FETCH,
   parameter int     MEM_WAIT_MAX = 15
) (
   input  logic                             clk,
   input  logic                             reset,
   multicycle_main_control_if.master        bus
);

   state_t state_q;
   state_t state_d;
   logic   timeout_q;
   logic   timeout_d;
   logic   w_sat;
   logic   w_mem_state;
   logic   w_hold;
   logic   w_abort;
   logic   w_unused_zero;

   // The branch decision itself lives in the datapath.
   assign w_unused_zero = bus.zero_i;

   assign w_mem_state = is_mem_state(state_q);
   assign w_abort     = w_mem_state && w_sat;
   assign w_hold      = w_mem_state && !w_sat && !bus.mem_ready_i;
   assign timeout_d   = timeout_q | w_abort;

   // Any non-holding cycle either leaves the state or re-enters FETCH.
   mem_wait_counter #(
      .WAIT_MAX (MEM_WAIT_MAX)
   ) u_wait_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear_i (!w_hold),
      .inc_i   (w_hold),
      .sat_o   (w_sat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RESET_STATE;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.mem_timeout_o = timeout_q;

   always_comb begin
      state_d             = state_q;
      bus.pc_write_o      = 1'b0;
      bus.pc_write_cond_o = 1'b0;
      bus.branch_ne_o     = 1'b0;
      bus.i_or_d_o        = 1'b0;
      bus.mem_read_o      = 1'b0;
      bus.mem_write_o     = 1'b0;
      bus.ir_write_o      = 1'b0;
      bus.reg_dst_o       = 1'b0;
      bus.mem_to_reg_o    = 1'b0;
      bus.reg_write_o     = 1'b0;
      bus.alu_src_a_o     = 1'b0;
      bus.alu_src_b_o     = SRCB_REG;
      bus.pc_source_o     = PCSRC_ALU;
      bus.alu_op_o        = ALUOP_ADD;
      bus.illegal_op_o    = 1'b0;

      case (state_q)
         S_FETCH: begin
            bus.mem_read_o  = !w_sat;
            bus.alu_src_b_o = SRCB_FOUR;
            if (w_sat) begin
               state_d = S_FETCH;
            end else if (bus.mem_ready_i) begin
               bus.pc_write_o = 1'b1;
               bus.ir_write_o = 1'b1;
               state_d        = S_DECODE;
            end
         end

         S_DECODE: begin
            bus.alu_src_b_o = SRCB_IMM_SH2;
            case (bus.opcode_i)
               OP_RTYPE:                        state_d = S_R_EXEC;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
               OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
               OP_J:                            state_d = S_JUMP;
               default: begin
                  bus.illegal_op_o = 1'b1;
                  state_d          = S_FETCH;
               end
            endcase
         end

         S_R_EXEC: begin
            bus.alu_src_a_o = 1'b1;
            bus.alu_src_b_o = SRCB_REG;
            bus.alu_op_o    = ALUOP_FUNCT;
            state_d         = S_R_WB;
         end

         S_R_WB: begin
            bus.reg_dst_o   = 1'b1;
            bus.reg_write_o = 1'b1;
            state_d         = S_FETCH;
         end

         S_I_EXEC: begin
            bus.alu_src_a_o = 1'b1;
            bus.alu_src_b_o = SRCB_IMM;
            bus.alu_op_o    = imm_alu_op(bus.opcode_i);
            state_d         = S_I_WB;
         end

         S_I_WB: begin
            bus.reg_write_o = 1'b1;
            state_d         = S_FETCH;
         end

         S_MEM_ADDR: begin
            bus.alu_src_a_o = 1'b1;
            bus.alu_src_b_o = SRCB_IMM;
            bus.alu_op_o    = ALUOP_MEM;
            if (bus.opcode_i == OP_LW) begin
               state_d = S_MEM_READ;
            end else if (bus.opcode_i == OP_SW) begin
               state_d = S_MEM_WRITE;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_MEM_READ: begin
            bus.i_or_d_o   = 1'b1;
            bus.mem_read_o = !w_sat;
            if (w_sat) begin
               state_d = S_FETCH;
            end else if (bus.mem_ready_i) begin
               state_d = S_MEM_WB;
            end
         end

         S_MEM_WB: begin
            bus.mem_to_reg_o = 1'b1;
            bus.reg_write_o  = 1'b1;
            state_d          = S_FETCH;
         end

         S_MEM_WRITE: begin
            bus.i_or_d_o    = 1'b1;
            bus.mem_write_o = !w_sat;
            if (w_sat || bus.mem_ready_i) begin
               state_d = S_FETCH;
            end
         end

         S_BRANCH: begin
            bus.alu_src_a_o     = 1'b1;
            bus.alu_src_b_o     = SRCB_REG;
            bus.alu_op_o        = ALUOP_SUB;
            bus.pc_write_cond_o = 1'b1;
            bus.pc_source_o     = PCSRC_ALUOUT;
            bus.branch_ne_o     = (bus.opcode_i == OP_BNE);
            state_d             = S_FETCH;
         end

         S_JUMP: begin
            bus.pc_write_o  = 1'b1;
            bus.pc_source_o = PCSRC_JUMP;
            state_d         = S_FETCH;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
// ============================================================================
//  Module     : tb_multicycle_main_control
//  Description: Scoreboard bench; per-cycle control words from an
//               instruction-level model, compared by a negedge monitor.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_main_control;

   localparam int WMAX = 15;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       illegal_op;
      logic       mem_timeout;
   } ctl_t;

   logic  clk;
   logic  reset;
   int    total;
   int    bad;
   bit    m_to;
   ctl_t  exp_q[$];
   string name_q[$];

   multicycle_main_control_if bus ();

   multicycle_main_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ctl_t sample();
      ctl_t a;
      a.pc_write      = bus.pc_write_o;
      a.pc_write_cond = bus.pc_write_cond_o;
      a.branch_ne     = bus.branch_ne_o;
      a.i_or_d        = bus.i_or_d_o;
      a.mem_read      = bus.mem_read_o;
      a.mem_write     = bus.mem_write_o;
      a.ir_write      = bus.ir_write_o;
      a.reg_dst       = bus.reg_dst_o;
      a.mem_to_reg    = bus.mem_to_reg_o;
      a.reg_write     = bus.reg_write_o;
      a.alu_src_a     = bus.alu_src_a_o;
      a.alu_src_b     = bus.alu_src_b_o;
      a.pc_source     = bus.pc_source_o;
      a.alu_op        = bus.alu_op_o;
      a.illegal_op    = bus.illegal_op_o;
      a.mem_timeout   = bus.mem_timeout_o;
      return a;
   endfunction

   // Monitor: one expected control word per cycle, checked mid-cycle.
   always @(negedge clk) begin
      ctl_t  e;
      ctl_t  a;
      string n;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = sample();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s @%0t: got %05h expected %05h", n, $time, a, e);
         end
      end
   end

   function automatic ctl_t base();
      ctl_t c;
      c             = '0;
      c.alu_op      = 3'b100;
      c.mem_timeout = m_to;
      return c;
   endfunction

   function automatic logic [5:0] rnd_op();
      return 6'($urandom);
   endfunction

   // 0 R-type, 1 I-type ALU, 2 LW, 3 SW, 4 branch, 5 jump, 6 undefined
   function automatic int op_class(input logic [5:0] op);
      case (op)
         6'h00:                      return 0;
         6'h08, 6'h0C, 6'h0D, 6'h0F: return 1;
         6'h23:                      return 2;
         6'h2B:                      return 3;
         6'h04, 6'h05:               return 4;
         6'h02:                      return 5;
         default:                    return 6;
      endcase
   endfunction

   function automatic logic [2:0] imm_op(input logic [5:0] op);
      case (op)
         6'h0C:   return 3'b011;
         6'h0D:   return 3'b001;
         6'h0F:   return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   task automatic step(input logic [5:0] op, input logic rdy, input logic rst_v,
                       input ctl_t e, input string n);
      @(posedge clk);
      #1;
      bus.opcode_i    = op;
      bus.mem_ready_i = rdy;
      bus.zero_i      = 1'($urandom);
      reset           = rst_v;
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   // kind: 0 = instruction fetch, 1 = data read, 2 = data write
   task automatic mem_phase(input int kind, input int waits, output bit ok);
      ctl_t e;
      ok = 1'b0;
      for (int c = 0; c <= WMAX; c++) begin
         e = base();
         if (kind == 0) e.alu_src_b = 2'b01;
         else           e.i_or_d    = 1'b1;
         if (c == WMAX) begin
            step(rnd_op(), 1'($urandom), 1'b0, e, "mem_abort");
            m_to = 1'b1;
            return;
         end
         if (kind == 2) e.mem_write = 1'b1;
         else           e.mem_read  = 1'b1;
         if (c == waits) begin
            if (kind == 0) begin
               e.pc_write = 1'b1;
               e.ir_write = 1'b1;
               step(rnd_op(), 1'b1, 1'b0, e, "fetch_done");
            end else begin
               step(rnd_op(), 1'b1, 1'b0, e, "mem_done");
            end
            ok = 1'b1;
            return;
         end
         step(rnd_op(), 1'b0, 1'b0, e, "mem_hold");
      end
   endtask

   task automatic exec_instr(input logic [5:0] op, input int mw);
      ctl_t e;
      bit   ok;
      int   cls;
      cls = op_class(op);
      e = base();
      e.alu_src_b = 2'b11;
      if (cls == 6) e.illegal_op = 1'b1;
      step(op, 1'($urandom), 1'b0, e, "decode");
      case (cls)
         0: begin
            e = base(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 3'b111;
            step(rnd_op(), 1'($urandom), 1'b0, e, "r_exec");
            e = base(); e.reg_dst = 1'b1; e.reg_write = 1'b1;
            step(rnd_op(), 1'($urandom), 1'b0, e, "r_wb");
         end
         1: begin
            e = base(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = imm_op(op);
            step(op, 1'($urandom), 1'b0, e, "i_exec");
            e = base(); e.reg_write = 1'b1;
            step(rnd_op(), 1'($urandom), 1'b0, e, "i_wb");
         end
         2, 3: begin
            e = base(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b101;
            step(op, 1'($urandom), 1'b0, e, "mem_addr");
            mem_phase((cls == 2) ? 1 : 2, mw, ok);
            if (ok && cls == 2) begin
               e = base(); e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
               step(rnd_op(), 1'($urandom), 1'b0, e, "mem_wb");
            end
         end
         4: begin
            e = base(); e.alu_src_a = 1'b1; e.alu_op = 3'b110; e.pc_write_cond = 1'b1;
            e.pc_source = 2'b01; e.branch_ne = (op == 6'h05);
            step(op, 1'($urandom), 1'b0, e, "branch");
         end
         5: begin
            e = base(); e.pc_write = 1'b1; e.pc_source = 2'b10;
            step(rnd_op(), 1'($urandom), 1'b0, e, "jump");
         end
         default: ;
      endcase
   endtask

   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      bit ok;
      mem_phase(0, fw, ok);
      if (ok) exec_instr(op, mw);
   endtask

   task automatic reset_mid_wait();
      ctl_t e;
      bit   ok;
      mem_phase(0, 0, ok);
      e = base(); e.alu_src_b = 2'b11;
      step(6'h2B, 1'b0, 1'b0, e, "decode");
      e = base(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b101;
      step(6'h2B, 1'b0, 1'b0, e, "mem_addr");
      e = base(); e.i_or_d = 1'b1; e.mem_write = 1'b1;
      for (int i = 0; i < 3; i++) step(rnd_op(), 1'b0, 1'b0, e, "mem_hold");
      step(rnd_op(), 1'b0, 1'b1, e, "rst_cycle");
      m_to = 1'b0;
      e = base(); e.alu_src_b = 2'b01; e.mem_read = 1'b1;
      step(rnd_op(), 1'b0, 1'b0, e, "after_rst");
      e.pc_write = 1'b1; e.ir_write = 1'b1;
      step(rnd_op(), 1'b1, 1'b0, e, "fetch_done");
      exec_instr(6'h00, 0);
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 11))
         0:       return 6'h00;
         1:       return 6'h02;
         2:       return 6'h04;
         3:       return 6'h05;
         4:       return 6'h08;
         5:       return 6'h0C;
         6:       return 6'h0D;
         7:       return 6'h0F;
         8:       return 6'h23;
         9:       return 6'h2B;
         default: return rnd_op();
      endcase
   endfunction

   function automatic int pick_wait();
      if ($urandom_range(0, 15) == 0) return WMAX + 1;
      return int'($urandom_range(0, 3));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      total           = 0;
      bad             = 0;
      m_to            = 1'b0;
      reset           = 1'b1;
      bus.opcode_i    = 6'h00;
      bus.mem_ready_i = 1'b0;
      bus.zero_i      = 1'b0;
      repeat (3) @(posedge clk);

      run_instr(6'h00, 1, 0);
      run_instr(6'h23, 0, 2);
      run_instr(6'h05, 0, 0);
      run_instr(6'h04, 2, 0);
      run_instr(6'h0D, 0, 0);
      run_instr(6'h0F, 0, 0);
      run_instr(6'h0C, 1, 0);
      run_instr(6'h08, 0, 0);
      run_instr(6'h3F, 0, 0);
      run_instr(6'h02, 0, 0);
      run_instr(6'h2B, 0, 1);
      run_instr(6'h2B, 0, 20);
      run_instr(6'h00, 20, 0);
      run_instr(6'h23, 0, WMAX - 1);
      reset_mid_wait();

      for (int i = 0; i < 80; i++) begin
         run_instr(pick_op(), pick_wait(), pick_wait());
      end

      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
